// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM encoding, master ids, response pipe entry.
// No logic of its own.
package ram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned M0 = 0;
  localparam int unsigned M1 = 1;

  typedef struct packed {
    logic vld;
    logic owner;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: grant is combinational from req, pointer flips after every grant.
// Zero latency; a loser waits at most one cycle. No backpressure beyond the grant itself.
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'(M0);
    end else if (|gnt_o) begin
      // Favour whoever did not just win.
      ptr_q <= gnt_o[0] ? 1'(M1) : 1'(M0);
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port RAM between two masters, with an optional clear sweep after reset.
// Grant same cycle; read data READ_LATENCY cycles after grant. Masters hold req until gnt.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEMORY_DEPTH   = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m0_req_i,
  input  logic                     m0_we_i,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0]    m0_wdata_i,
  output logic                     m0_gnt_o,
  output logic                     m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]    m0_rdata_o,
  input  logic                     m1_req_i,
  input  logic                     m1_we_i,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0]    m1_wdata_i,
  output logic                     m1_gnt_o,
  output logic                     m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]    m1_rdata_o,
  output logic                     ram_we_o,
  output logic [ADDRESS_WIDTH-1:0] ram_address_o,
  output logic [DATA_WIDTH-1:0]    ram_data_o,
  input  logic [DATA_WIDTH-1:0]    ram_data_i,
  output logic                     init_done_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q;
  logic [1:0]               gnt;
  logic                     run_en;
  logic                     rd_grant;
  rsp_t                     rsp_in;
  rsp_t                     rsp_out;
  rsp_t                     pipe_q [READ_LATENCY];

  // rst_i is gated in so nothing is granted or returned while reset is being applied.
  assign run_en = (state_q == ST_RUN) && !rst_i;

  rr_arbiter_2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (run_en),
    .req_i ({m1_req_i, m0_req_i}),
    .gnt_o (gnt)
  );

  assign m0_gnt_o = gnt[M0];
  assign m1_gnt_o = gnt[M1];

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  assign init_done_o = (state_q == ST_RUN);

  always_comb begin
    ram_we_o      = 1'b0;
    ram_address_o = '0;
    ram_data_o    = '0;
    rd_grant      = 1'b0;
    if (state_q == ST_CLEAR && !rst_i) begin
      ram_we_o      = 1'b1;
      ram_address_o = clr_cnt_q;
      ram_data_o    = CLEAR_VALUE;
    end else if (gnt[M0]) begin
      ram_we_o      = m0_we_i;
      ram_address_o = m0_addr_i;
      ram_data_o    = m0_wdata_i;
      rd_grant      = !m0_we_i;
    end else if (gnt[M1]) begin
      ram_we_o      = m1_we_i;
      ram_address_o = m1_addr_i;
      ram_data_o    = m1_wdata_i;
      rd_grant      = !m1_we_i;
    end
  end

  assign rsp_in = '{vld: rd_grant, owner: gnt[M1]};

  // Stage k holds the read granted k+1 cycles ago; the last stage lines up with ram_data_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rsp_in;
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_out     = pipe_q[READ_LATENCY-1];
  assign m0_rvalid_o = rsp_out.vld && !rst_i && (rsp_out.owner == 1'(M0));
  assign m1_rvalid_o = rsp_out.vld && !rst_i && (rsp_out.owner == 1'(M1));
  assign m0_rdata_o  = m0_rvalid_o ? ram_data_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? ram_data_i : '0;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p beside a 32x32 single-port RAM with one cycle of read latency.
module tb_ram_arbiter_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [4:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [4:0]  ram_address;
  logic [31:0] ram_wdata, ram_rdata;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_we_o(ram_we), .ram_address_o(ram_address), .ram_data_o(ram_wdata),
    .ram_data_i(ram_rdata), .init_done_o(init_done)
  );

  // Read-first single-port RAM, one cycle from address sample to data.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  initial begin
    int waited;
    idle_all();
    rst = 1;
    step(); step();
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}, 0);

    // Clear sweep: m0 requests throughout and must never be granted.
    step();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      m0_req = 1;
      @(negedge clk);
      chk("clr_we", ram_we, 1);
      chk("clr_addr", ram_address, i);
      chk("clr_data", ram_wdata, 0);
      chk("clr_done_low", init_done, 0);
      chk("clr_no_gnt", m0_gnt, 0);
      step();
      m0_req = 0;
    end
    @(negedge clk);
    chk("clr_done_c32", init_done, 1);
    chk("idle_we", ram_we, 0);

    // Write then read-after-write from the other master.
    step();
    m0_req = 1; m0_we = 1; m0_addr = 5'd3; m0_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("wr_ram", {ram_we, 3'b0, ram_address, ram_wdata[23:0]}, {1'b1, 3'b0, 5'd3, 24'h345678});
    step();
    idle_all();
    m1_req = 1; m1_addr = 5'd3;
    @(negedge clk);
    chk("raw_gnt", {m0_gnt, m1_gnt, ram_we}, 3'b010);
    chk("raw_rvalid_early", m1_rvalid, 0);
    step();
    m1_req = 1; m1_we = 1; m1_addr = 5'd5; m1_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("raw_rvalid", m1_rvalid, 1);
    chk("raw_rdata", m1_rdata, 32'h1234_5678);
    chk("raw_m0_quiet", {m0_rvalid, m0_rdata}, 0);
    chk("wr5_gnt", m1_gnt, 1);

    // Contending reads for 4 cycles: pointer now favours m0.
    step();
    idle_all();
    m0_req = 1; m0_addr = 5'd3;
    m1_req = 1; m1_addr = 5'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt", {m0_gnt, m1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("rr_rvalid", {m0_rvalid, m1_rvalid}, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk("rr_rdata", m0_rdata | m1_rdata, (k % 2 == 0) ? 32'hCAFE_F00D : 32'h1234_5678);
      end
      step();
    end
    idle_all();
    @(negedge clk);
    chk("rr_last_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("rr_last_rdata", m1_rdata, 32'hCAFE_F00D);

    // m1 alone every cycle, then m0 joins and wins.
    step();
    m1_req = 1; m1_addr = 5'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("solo_gnt", m1_gnt, 1);
      if (k > 0) chk("solo_rdata", m1_rdata, 32'hCAFE_F00D);
      step();
    end
    m0_req = 1; m0_addr = 5'd3;
    @(negedge clk);
    chk("join_gnt", {m0_gnt, m1_gnt}, 2'b10);
    step();
    idle_all();
    @(negedge clk);
    chk("join_rdata", m0_rdata, 32'h1234_5678);
    chk("noreq_ram", {ram_we, ram_address, ram_wdata}, 0);

    // Write DEADBEEF @7, confirm it landed, then reset right after a granted read.
    step();
    m0_req = 1; m0_we = 1; m0_addr = 5'd7; m0_wdata = 32'hDEAD_BEEF;
    step();
    idle_all();
    m1_req = 1; m1_addr = 5'd7;
    step();
    m1_req = 0;
    @(negedge clk);
    chk("pre_rst_rdata", m1_rdata, 32'hDEAD_BEEF);
    step();
    m0_req = 1; m0_addr = 5'd7;
    @(negedge clk);
    chk("pre_rst_gnt", m0_gnt, 1);
    step();
    idle_all();
    rst = 1;
    @(negedge clk);
    chk("rst_drop_rvalid", {m0_rvalid, m1_rvalid, m0_rdata}, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("restart_sweep", {ram_we, ram_address, init_done}, {1'b1, 5'd0, 1'b0});
    waited = 0;
    while (!init_done && waited < 100) begin
      step();
      waited++;
      @(negedge clk);
    end
    chk("reinit_done", init_done, 1);
    chk("reinit_cycles", waited, 32);

    step();
    m0_req = 1; m0_addr = 5'd7;
    @(negedge clk);
    chk("post_clr_gnt", m0_gnt, 1);
    step();
    idle_all();
    @(negedge clk);
    chk("post_clr_rvalid", m0_rvalid, 1);
    chk("post_clr_rdata", m0_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
